// File: rtl/ingress_classifier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ingress_classifier_pkg
// Purpose  : Shared types and constants for the ingress classifier slice:
//            egress port count, AXIS beat structs, register map addresses,
//            classifier FSM state encoding and a MAC byte-select helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ingress_classifier_pkg;

  localparam int NUM_EGRESS_PORTS = 4;
  localparam int TDEST_W          = $clog2(NUM_EGRESS_PORTS);

  typedef struct packed {
    logic [15:0] tdata;
    logic        tlast;
  } axis_source_t;

  typedef struct packed {
    logic [15:0]        tdata;
    logic               tlast;
    logic [TDEST_W-1:0] tdest;
  } axis_d_source_t;

  // Register map
  localparam logic [7:0] ADDR_CTRL       = 8'h00;
  localparam logic [7:0] ADDR_DROPS      = 8'h01;
  localparam logic [7:0] ADDR_TABLE_BASE = 8'h10;
  localparam int         ENTRY_STRIDE    = 8;
  localparam logic [2:0] ENTRY_CFG_BYTE  = 3'd6;

  typedef enum logic [2:0] {
    ST_HDR      = 3'd0,
    ST_DECIDE   = 3'd1,
    ST_FWD_HDR  = 3'd2,
    ST_FWD_BODY = 3'd3,
    ST_DROP     = 3'd4
  } state_e;

  // Byte k of a MAC, byte 0 being the first byte on the wire (MSB end).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] k);
    logic [7:0] b;
    case (k)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      default: b = mac[7:0];
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ingress_classifier_if.sv
`default_nettype none
// ============================================================================
// Module   : ingress_classifier_if
// Purpose  : Bundles the Avalon-MM programming port, ingress AXIS, egress
//            AXIS (with tdest) and the interrupt line of the classifier.
// Modports : master - traffic/CPU side driving the classifier
//            slave  - the classifier itself
// Revision : 1.0 - initial release
// ============================================================================
interface ingress_classifier_if;
  import ingress_classifier_pkg::*;

  logic [7:0]         writedata;
  logic               write;
  logic               chipselect;
  logic [7:0]         address;
  logic               read;
  logic [7:0]         readdata;

  logic [15:0]        in_tdata;
  logic               in_tvalid;
  logic               in_tready;
  logic               in_tlast;

  logic [15:0]        out_tdata;
  logic               out_tvalid;
  logic               out_tready;
  logic               out_tlast;
  logic [TDEST_W-1:0] out_tdest;

  logic               irq;

  modport master (
    output writedata, write, chipselect, address, read,
    input  readdata,
    output in_tdata, in_tvalid, in_tlast,
    input  in_tready,
    input  out_tdata, out_tvalid, out_tlast, out_tdest,
    output out_tready,
    input  irq
  );

  modport slave (
    input  writedata, write, chipselect, address, read,
    output readdata,
    input  in_tdata, in_tvalid, in_tlast,
    output in_tready,
    output out_tdata, out_tvalid, out_tlast, out_tdest,
    input  out_tready,
    output irq
  );

endinterface
`default_nettype wire

// File: rtl/ingress_classifier_mac_lookup_table.sv
`default_nettype none
// ============================================================================
// Module   : mac_lookup_table
// Purpose  : Software-programmed MAC table. Holds NUM_ENTRIES entries
//            (6 MAC bytes, valid, port), decodes their Avalon byte addresses
//            and performs a combinational match, lowest index winning.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            wr_en_i           - qualified Avalon write (chipselect&&write)
//            addr_i, wdata_i   - Avalon byte address / write data
//            rdata_o           - combinational read data (0 if unmapped)
//            mac_i             - MAC to look up
//            hit_o, port_o     - match result and matched entry's port
// Revision : 1.0 - initial release
// ============================================================================
module mac_lookup_table
  import ingress_classifier_pkg::*;
#(
  parameter int NUM_ENTRIES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en_i,
  input  logic [7:0]         addr_i,
  input  logic [7:0]         wdata_i,
  output logic [7:0]         rdata_o,
  input  logic [47:0]        mac_i,
  output logic               hit_o,
  output logic [TDEST_W-1:0] port_o
);

  localparam logic [7:0] c_END = 8'(ADDR_TABLE_BASE + ENTRY_STRIDE * NUM_ENTRIES);

  logic [47:0]        mac_q   [NUM_ENTRIES];
  logic               valid_q [NUM_ENTRIES];
  logic [TDEST_W-1:0] port_q  [NUM_ENTRIES];

  logic       w_in_range;
  logic [3:0] w_idx;
  logic [2:0] w_byte;

  // Table occupies 0x10..0x10+8*N-1; bits[6:3] minus 2 give the entry index.
  assign w_in_range = (addr_i >= ADDR_TABLE_BASE) && (addr_i < c_END);
  assign w_idx      = addr_i[6:3] - 4'd2;
  assign w_byte     = addr_i[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mac_q[i]   <= '0;
        valid_q[i] <= 1'b0;
        port_q[i]  <= '0;
      end
    end else if (wr_en_i && w_in_range) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_idx == 4'(i)) begin
          case (w_byte)
            3'd0: mac_q[i][47:40] <= wdata_i;
            3'd1: mac_q[i][39:32] <= wdata_i;
            3'd2: mac_q[i][31:24] <= wdata_i;
            3'd3: mac_q[i][23:16] <= wdata_i;
            3'd4: mac_q[i][15:8]  <= wdata_i;
            3'd5: mac_q[i][7:0]   <= wdata_i;
            ENTRY_CFG_BYTE: begin
              valid_q[i] <= wdata_i[7];
              port_q[i]  <= wdata_i[TDEST_W-1:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    if (w_in_range) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_idx == 4'(i)) begin
          if (w_byte == ENTRY_CFG_BYTE)
            rdata_o = {valid_q[i], {(7-TDEST_W){1'b0}}, port_q[i]};
          else if (w_byte != 3'd7)
            rdata_o = mac_byte(mac_q[i], w_byte);
        end
      end
    end
  end

  // Scan from the top down so the lowest matching index overrides.
  always_comb begin
    hit_o  = 1'b0;
    port_o = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (mac_q[i] == mac_i)) begin
        hit_o  = 1'b1;
        port_o = port_q[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ingress_classifier.sv
`default_nettype none
// ============================================================================
// Module   : ingress_classifier
// Purpose  : Buffers the 3 header beats of each ingress frame, looks up the
//            destination MAC and either forwards the frame with tdest or
//            drops it. CTRL/DROPS registers and table on an 8-bit Avalon port.
// Ports    : clk, reset - clock, synchronous active-high reset
//            bus        - ingress_classifier_if.slave (Avalon, AXIS in/out, irq)
// Options  : INGRESS_CLASSIFIER_IRQ_EN - builds the level interrupt raised on
//            drops and cleared by a write to DROPS; otherwise irq is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module ingress_classifier
  import ingress_classifier_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int HDR_BEATS   = 3
) (
  input logic            clk,
  input logic            reset,
  ingress_classifier_if.slave bus
);

  localparam logic [1:0] c_LAST_HDR = 2'(HDR_BEATS - 1);

  state_e             state_q;
  logic [1:0]         hdr_cnt_q;
  logic [1:0]         emit_cnt_q;
  logic [15:0]        hdr_q [HDR_BEATS];
  logic               last_q;
  logic [TDEST_W-1:0] tdest_q;
  logic [3:0]         ctrl_q;
  logic [7:0]         drops_q;
  logic [7:0]         readdata_q;

  logic               w_reg_wr, w_reg_rd, w_drops_wr;
  logic               w_in_fire, w_out_fire;
  logic               w_in_tready, w_out_tvalid;
  axis_d_source_t     w_out;
  logic [7:0]         w_tbl_rdata, w_rdata;
  logic               w_hit, w_fwd, w_drop;
  logic [TDEST_W-1:0] w_hit_port, w_dec_tdest;

  assign w_reg_wr   = bus.chipselect && bus.write;
  assign w_reg_rd   = bus.chipselect && bus.read;
  assign w_drops_wr = w_reg_wr && (bus.address == ADDR_DROPS);
  assign w_in_fire  = bus.in_tvalid && w_in_tready;
  assign w_out_fire = w_out_tvalid && bus.out_tready;

  mac_lookup_table #(.NUM_ENTRIES(NUM_ENTRIES)) u_table (
    .clk     (clk),
    .reset   (reset),
    .wr_en_i (w_reg_wr),
    .addr_i  (bus.address),
    .wdata_i (bus.writedata),
    .rdata_o (w_tbl_rdata),
    .mac_i   ({hdr_q[0], hdr_q[1], hdr_q[2]}),
    .hit_o   (w_hit),
    .port_o  (w_hit_port)
  );

  // ctrl: [0] enable, [1] miss_drop, [3:2] default_port
  assign w_fwd       = !ctrl_q[0] || w_hit || !ctrl_q[1];
  assign w_dec_tdest = (ctrl_q[0] && w_hit) ? w_hit_port : ctrl_q[3:2];

  always_comb begin
    w_drop = 1'b0;
    case (state_q)
      ST_HDR:    w_drop = w_in_fire && bus.in_tlast && (hdr_cnt_q != c_LAST_HDR);
      ST_DECIDE: w_drop = !w_fwd;
      default:   ;
    endcase
  end

  always_comb begin
    w_rdata = w_tbl_rdata;
    if (bus.address == ADDR_CTRL)       w_rdata = {4'b0, ctrl_q};
    else if (bus.address == ADDR_DROPS) w_rdata = drops_q;
  end

  // Header beats come from the buffer; body beats pass straight through.
  // Handshake outputs are forced low while reset is held.
  always_comb begin
    w_out        = '0;
    w_out.tdest  = tdest_q;
    w_out_tvalid = 1'b0;
    w_in_tready  = 1'b0;
    case (state_q)
      ST_HDR, ST_DROP: w_in_tready = 1'b1;
      ST_FWD_HDR: begin
        w_out_tvalid = 1'b1;
        w_out.tdata  = hdr_q[emit_cnt_q];
        w_out.tlast  = last_q && (emit_cnt_q == c_LAST_HDR);
      end
      ST_FWD_BODY: begin
        w_out_tvalid = bus.in_tvalid;
        w_in_tready  = bus.out_tready;
        w_out.tdata  = bus.in_tdata;
        w_out.tlast  = bus.in_tlast;
      end
      default: ;
    endcase
    if (reset) begin
      w_out_tvalid = 1'b0;
      w_in_tready  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HDR;
      hdr_cnt_q  <= '0;
      emit_cnt_q <= '0;
      last_q     <= 1'b0;
      tdest_q    <= '0;
      ctrl_q     <= '0;
      drops_q    <= '0;
      readdata_q <= '0;
      for (int i = 0; i < HDR_BEATS; i++) hdr_q[i] <= '0;
    end else begin
      if (w_reg_wr && (bus.address == ADDR_CTRL)) ctrl_q <= bus.writedata[3:0];
      // A drop coinciding with the clear is counted after the clear.
      if (w_drop)
        drops_q <= w_drops_wr ? 8'd1 : ((drops_q == 8'hFF) ? drops_q : drops_q + 8'd1);
      else if (w_drops_wr)
        drops_q <= '0;
      if (w_reg_rd) readdata_q <= w_rdata;

      case (state_q)
        ST_HDR: begin
          if (w_in_fire) begin
            hdr_q[hdr_cnt_q] <= bus.in_tdata;
            if (hdr_cnt_q == c_LAST_HDR) begin
              last_q    <= bus.in_tlast;
              hdr_cnt_q <= '0;
              state_q   <= ST_DECIDE;
            end else if (bus.in_tlast) begin
              hdr_cnt_q <= '0;
            end else begin
              hdr_cnt_q <= hdr_cnt_q + 2'd1;
            end
          end
        end
        ST_DECIDE: begin
          if (w_fwd) begin
            tdest_q    <= w_dec_tdest;
            emit_cnt_q <= '0;
            state_q    <= ST_FWD_HDR;
          end else begin
            state_q <= last_q ? ST_HDR : ST_DROP;
          end
        end
        ST_FWD_HDR: begin
          if (w_out_fire) begin
            if (emit_cnt_q == c_LAST_HDR) state_q <= last_q ? ST_HDR : ST_FWD_BODY;
            else                          emit_cnt_q <= emit_cnt_q + 2'd1;
          end
        end
        ST_FWD_BODY, ST_DROP: begin
          if (w_in_fire && bus.in_tlast) state_q <= ST_HDR;
        end
        default: state_q <= ST_HDR;
      endcase
    end
  end

`ifdef INGRESS_CLASSIFIER_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk) begin
    if (reset)           irq_q <= 1'b0;
    else if (w_drop)     irq_q <= 1'b1;
    else if (w_drops_wr) irq_q <= 1'b0;
  end
  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

  assign bus.readdata   = readdata_q;
  assign bus.in_tready  = w_in_tready;
  assign bus.out_tvalid = w_out_tvalid;
  assign bus.out_tdata  = w_out.tdata;
  assign bus.out_tlast  = w_out.tlast;
  assign bus.out_tdest  = w_out.tdest;

endmodule
`default_nettype wire

// File: tb/tb_ingress_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_ingress_classifier
// Purpose  : Scoreboard bench for ingress_classifier. Stimulus pushes the
//            expected egress beats; an independent monitor pops and compares
//            on every egress handshake and checks stall stability.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ingress_classifier;
  import ingress_classifier_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic stall_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [18:0] sb [$];  // {tdata, tlast, tdest}

  ingress_classifier_if bus ();

  ingress_classifier #(.NUM_ENTRIES(4), .HDR_BEATS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic reg_rd(input logic [7:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.read = 1'b0;
    d = bus.readdata;
  endtask

  // Call at posedge+#1; returns at posedge+#1 after the beat was accepted.
  task automatic send_beat(input logic [15:0] d, input logic last, inout int waits);
    int   guard;
    logic acc;
    guard = 0;
    acc   = 1'b0;
    bus.in_tvalid = 1'b1; bus.in_tdata = d; bus.in_tlast = last;
    while (!acc) begin
      @(negedge clk); acc = bus.in_tready;
      @(posedge clk); #1;
      if (!acc) begin
        waits++; guard++;
        if (guard > 100) begin
          n_tests++; n_fail++;
          $display("FAIL send_timeout: in_tready never rose for beat 0x%0h", d);
          acc = 1'b1;
        end
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] beats [$], output int waits);
    waits = 0;
    @(posedge clk); #1;
    foreach (beats[i]) send_beat(beats[i], (i == beats.size() - 1), waits);
    bus.in_tvalid = 1'b0; bus.in_tlast = 1'b0;
  endtask

  task automatic expect_frame(input logic [15:0] beats [$], input logic [1:0] dest);
    foreach (beats[i]) sb.push_back({beats[i], (i == beats.size() - 1) ? 1'b1 : 1'b0, dest});
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin @(posedge clk); guard++; end
    chk("drain_pending_beats", sb.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  // Sink: ready high, or a 5-low/3-high pattern while stall_en is set.
  initial begin
    int cyc;
    cyc = 0;
    bus.out_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.out_tready = !(stall_en && ((cyc % 8) < 5));
    end
  end

  // Monitor
  initial begin
    logic        held_v;
    logic [18:0] held, act, exp;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_v = 1'b0;
      end else begin
        act = {bus.out_tdata, bus.out_tlast, bus.out_tdest};
        if (held_v) begin
          chk("stall_valid_held", bus.out_tvalid, 1);
          chk("stall_beat_stable", act, held);
        end
        if (bus.out_tvalid && !bus.out_tready) begin
          chk("stall_in_tready_low", bus.in_tready, 0);
          held_v = 1'b1;
          held   = act;
        end else begin
          held_v = 1'b0;
        end
        if (bus.out_tvalid && bus.out_tready) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat", act);
          end else begin
            exp = sb.pop_front();
            chk("out_beat{data,last,dest}", act, exp);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fr [$];
    logic [7:0]  rd;
    int          w;
    logic [15:0] mac_a [3];
    mac_a[0] = 16'h0011; mac_a[1] = 16'h2233; mac_a[2] = 16'h4455;

    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = '0; bus.writedata = '0;
    bus.in_tvalid = 1'b0; bus.in_tdata = '0; bus.in_tlast = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readdata", bus.readdata, 0);
    chk("rst_out_tvalid", bus.out_tvalid, 0);
    chk("rst_out_tlast", bus.out_tlast, 0);
    chk("rst_out_tdest", bus.out_tdest, 0);
    chk("rst_out_tdata", bus.out_tdata, 0);
    chk("rst_in_tready", bus.in_tready, 0);
    chk("rst_irq", bus.irq, 0);
    reset = 1'b0;
    reg_rd(8'h00, rd); chk("rst_ctrl", rd, 8'h00);
    reg_rd(8'h01, rd); chk("rst_drops", rd, 8'h00);
    reg_rd(8'h16, rd); chk("rst_entry0_cfg", rd, 8'h00);

    // Program entry0 = 00:11:22:33:44:55 -> port 2, enable
    for (int k = 0; k < 6; k++) reg_wr(8'(8'h10 + k), 8'(8'h11 * k));
    reg_wr(8'h16, 8'h82);
    reg_wr(8'h00, 8'h01);
    reg_rd(8'h13, rd); chk("entry0_byte3", rd, 8'h33);
    reg_rd(8'h16, rd); chk("entry0_cfg", rd, 8'h82);
    reg_rd(8'h17, rd); chk("unmapped_17", rd, 8'h00);
    reg_wr(8'h30, 8'h5A);
    reg_rd(8'h30, rd); chk("unmapped_30", rd, 8'h00);

    // Hit: 6-beat frame -> tdest 2
    fr = '{16'h0011, 16'h2233, 16'h4455, 16'hA001, 16'hA002, 16'hA003};
    expect_frame(fr, 2'd2);
    send_frame(fr, w);
    drain();

    // Miss with miss_drop: dropped, only the DECIDE cycle stalls ingress
    reg_wr(8'h00, 8'h03);
    fr = '{16'hDEAD, 16'hBEEF, 16'h0001, 16'hB001, 16'hB002, 16'hB003};
    send_frame(fr, w);
    chk("drop_ingress_waits", w, 1);
    drain();
    reg_rd(8'h01, rd); chk("drops_after_miss", rd, 8'h01);
`ifdef INGRESS_CLASSIFIER_IRQ_EN
    chk("irq_set_on_drop", bus.irq, 1);
    reg_wr(8'h01, 8'h00);
    chk("irq_cleared", bus.irq, 0);
`else
    chk("irq_tied_low", bus.irq, 0);
    reg_wr(8'h01, 8'h00);
`endif
    reg_rd(8'h01, rd); chk("drops_cleared", rd, 8'h00);

    // Miss, default port 3
    reg_wr(8'h00, 8'h0D);
    fr = '{16'h0102, 16'h0304, 16'h0506, 16'hC001};
    expect_frame(fr, 2'd3);
    send_frame(fr, w);
    drain();

    // Runt of 2 beats, then a legal 3-beat frame
    fr = '{16'h0011, 16'h2233};
    send_frame(fr, w);
    drain();
    reg_rd(8'h01, rd); chk("drops_after_runt", rd, 8'h01);
    fr = '{mac_a[0], mac_a[1], mac_a[2]};
    expect_frame(fr, 2'd2);
    send_frame(fr, w);
    drain();

    // Back-pressure across header and body
    stall_en = 1'b1;
    fr = '{mac_a[0], mac_a[1], mac_a[2], 16'hD001, 16'hD002, 16'hD003, 16'hD004, 16'hD005};
    expect_frame(fr, 2'd2);
    send_frame(fr, w);
    drain();
    stall_en = 1'b0;

    // Entries 0 and 1 both match: lowest index wins
    reg_wr(8'h16, 8'h81);
    for (int k = 0; k < 6; k++) reg_wr(8'(8'h18 + k), 8'(8'h11 * k));
    reg_wr(8'h1E, 8'h82);
    fr = '{mac_a[0], mac_a[1], mac_a[2], 16'hE001};
    expect_frame(fr, 2'd1);
    send_frame(fr, w);
    drain();
    reg_wr(8'h16, 8'h01);
    fr = '{mac_a[0], mac_a[1], mac_a[2], 16'hE002};
    expect_frame(fr, 2'd2);
    send_frame(fr, w);
    drain();

    // enable=0 forwards to default port 0 even with miss_drop set
    reg_wr(8'h00, 8'h02);
    fr = '{16'h7777, 16'h8888, 16'h9999, 16'hF001};
    expect_frame(fr, 2'd0);
    send_frame(fr, w);
    drain();

    // DROPS saturation with single-beat runts
    reg_wr(8'h01, 8'hA5);
    for (int k = 0; k < 260; k++) begin
      fr = '{16'(k)};
      send_frame(fr, w);
    end
    reg_rd(8'h01, rd); chk("drops_saturated", rd, 8'hFF);
    reg_wr(8'h01, 8'h3C);
    reg_rd(8'h01, rd); chk("drops_write_clears", rd, 8'h00);

    // Reset in the middle of a forwarded body
    reg_wr(8'h00, 8'h01);
    fr = '{mac_a[0], mac_a[1], mac_a[2], 16'h5001, 16'h5002,
           16'h5003, 16'h5004, 16'h5005, 16'h5006, 16'h5007};
    for (int i = 0; i < 5; i++) sb.push_back({fr[i], 1'b0, 2'd2});
    @(posedge clk); #1;
    w = 0;
    for (int i = 0; i < 5; i++) send_beat(fr[i], 1'b0, w);
    bus.in_tvalid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_tvalid", bus.out_tvalid, 0);
    chk("midrst_out_tlast", bus.out_tlast, 0);
    chk("midrst_out_tdata", bus.out_tdata, 0);
    chk("midrst_out_tdest", bus.out_tdest, 0);
    chk("midrst_in_tready", bus.in_tready, 0);
    chk("midrst_readdata", bus.readdata, 0);
    chk("midrst_irq", bus.irq, 0);
    chk("midrst_beats_consumed", sb.size(), 0);
    reset = 1'b0;
    // Remaining beats form a new frame; control is cleared -> default port 0
    fr = '{16'h5003, 16'h5004, 16'h5005, 16'h5006, 16'h5007};
    expect_frame(fr, 2'd0);
    send_frame(fr, w);
    drain();
    reg_rd(8'h01, rd); chk("midrst_drops", rd, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
